// File: rtl/dcache_mem_port.sv
// Memory-side port of the data cache: moves one 16-byte line between the cache
// and the byte-wide RAM bus, either as a line fill or as a line write-back.
module dcache_mem_port #(
   parameter int BLOCK_WIDTH = 4,
   parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
   input  logic                    clkIn,
   input  logic                    resetIn,
   input  logic                    readyIn,
   input  logic                    missIn,
   input  logic [31:BLOCK_WIDTH]   missAddrIn,
   input  logic                    readWriteIn,
   input  logic [BLOCK_SIZE*8-1:0] writeBackIn,
   input  logic [7:0]              ramDataIn,
   output logic [31:0]             ramAddrOut,
   output logic [7:0]              ramDataOut,
   output logic                    ramWriteOut,
   output logic                    memDataValid,
   output logic [31:BLOCK_WIDTH]   memAddr,
   output logic [BLOCK_SIZE*8-1:0] memDataOut,
   output logic                    acceptWrite,
   output logic                    busy
);

   localparam int CW = BLOCK_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [31:BLOCK_WIDTH]   line_addr_q;
   logic [BLOCK_SIZE*8-1:0] buf_q;
   logic [BLOCK_SIZE*8-1:0] buf_d;
   logic                    stall_q;
   logic                    mem_valid_q;
   logic                    accept_q;
   logic [31:BLOCK_WIDTH]   mem_addr_q;
   logic [BLOCK_SIZE*8-1:0] mem_data_q;
   logic [BLOCK_WIDTH-1:0]  ram_byte_s;
   logic [BLOCK_WIDTH-1:0]  cap_idx_s;

   // RAM data lags its address by one cycle, so byte cnt-1 arrives while cnt is presented
   always_comb begin
      cap_idx_s = cnt_q[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(1);
      buf_d     = buf_q;
      if (cnt_q != CW'(0)) begin
         buf_d[{cap_idx_s, 3'b000} +: 8] = ramDataIn;
      end else begin
         buf_d = buf_q;
      end
   end

   // RAM bus drive; the address parks on the last byte once cnt wraps past it
   always_comb begin
      ram_byte_s  = cnt_q[BLOCK_WIDTH] ? {BLOCK_WIDTH{1'b1}} : cnt_q[BLOCK_WIDTH-1:0];
      ramAddrOut  = 32'h0000_0000;
      ramDataOut  = 8'h00;
      ramWriteOut = 1'b0;
      case (state_q)
         READ: begin
            ramAddrOut = {line_addr_q, ram_byte_s};
         end
         WRITE: begin
            ramAddrOut  = {line_addr_q, ram_byte_s};
            ramDataOut  = buf_q[{ram_byte_s, 3'b000} +: 8];
            ramWriteOut = readyIn & ~stall_q;
         end
         default: begin
            ramWriteOut = 1'b0;
         end
      endcase
   end

   // Transfer FSM with registered completion pulses and result holding registers
   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         state_q     <= IDLE;
         cnt_q       <= CW'(0);
         line_addr_q <= '0;
         buf_q       <= '0;
         stall_q     <= 1'b0;
         mem_valid_q <= 1'b0;
         accept_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
      end else if (readyIn) begin
         case (state_q)
            IDLE: begin
               if (missIn) begin
                  line_addr_q <= missAddrIn;
                  cnt_q       <= CW'(0);
                  state_q     <= readWriteIn ? READ : WRITE;
                  if (!readWriteIn) begin
                     buf_q <= writeBackIn;
                  end
               end
            end
            READ: begin
               // a stall breaks the one-cycle RAM pipeline, so the line is refetched
               if (stall_q) begin
                  cnt_q   <= CW'(0);
                  stall_q <= 1'b0;
               end else begin
                  buf_q <= buf_d;
                  if (cnt_q == CW'(BLOCK_SIZE)) begin
                     state_q     <= DONE;
                     mem_valid_q <= 1'b1;
                     mem_addr_q  <= line_addr_q;
                     mem_data_q  <= buf_d;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            WRITE: begin
               if (stall_q) begin
                  cnt_q   <= CW'(0);
                  stall_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CW'(BLOCK_SIZE - 1)) begin
                     state_q    <= DONE;
                     accept_q   <= 1'b1;
                     mem_addr_q <= line_addr_q;
                     mem_data_q <= buf_q;
                  end
               end
            end
            DONE: begin
               state_q     <= IDLE;
               mem_valid_q <= 1'b0;
               accept_q    <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end else if ((state_q == READ) || (state_q == WRITE)) begin
         stall_q <= 1'b1;
      end
   end

   assign memDataValid = mem_valid_q;
   assign acceptWrite  = accept_q;
   assign memAddr      = mem_addr_q;
   assign memDataOut   = mem_data_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_mem_port.sv
// Scoreboard bench for dcache_mem_port: a byte RAM model plus queues of
// expected RAM writes and expected completed transfers.
module tb_dcache_mem_port;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ready;
   logic         miss;
   logic         rw;
   logic [31:4]  maddr;
   logic [127:0] wb;
   logic [7:0]   ram_rd;
   logic [31:0]  ramAddrOut;
   logic [7:0]   ramDataOut;
   logic         ramWriteOut;
   logic         memDataValid;
   logic [31:4]  memAddr;
   logic [127:0] memDataOut;
   logic         acceptWrite;
   logic         busy;

   always #5 clk = ~clk;

   dcache_mem_port #(.BLOCK_WIDTH(4)) dut (
      .clkIn        (clk),
      .resetIn      (rst_n),
      .readyIn      (ready),
      .missIn       (miss),
      .missAddrIn   (maddr),
      .readWriteIn  (rw),
      .writeBackIn  (wb),
      .ramDataIn    (ram_rd),
      .ramAddrOut   (ramAddrOut),
      .ramDataOut   (ramDataOut),
      .ramWriteOut  (ramWriteOut),
      .memDataValid (memDataValid),
      .memAddr      (memAddr),
      .memDataOut   (memDataOut),
      .acceptWrite  (acceptWrite),
      .busy         (busy)
   );

   typedef struct {
      bit           fill;
      logic [31:4]  addr;
      logic [127:0] data;
   } xfer_t;

   xfer_t       xfer_q[$];
   logic [39:0] wr_q[$];
   logic [7:0]  ram [0:65535];

   int          n_vec = 0;
   int          n_err = 0;
   int          fill_pulses = 0;
   int          acc_pulses = 0;
   int          wr_count = 0;
   logic        mdv_prev = 1'b0;
   logic        acc_prev = 1'b0;
   int          stall_at = -1;
   int          stall_len = 0;
   bit          chk_en = 1'b0;
   logic [31:0] chk_base = 32'h0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic take_xfer(input bit is_fill);
      xfer_t e;
      check_eq(is_fill ? "fill_pulse_expected" : "wb_pulse_expected",
               128'((xfer_q.size() != 0) && (xfer_q[0].fill == is_fill)), 128'(1));
      if (xfer_q.size() != 0) begin
         e = xfer_q.pop_front();
         check_eq("xfer_addr", 128'(memAddr), 128'(e.addr));
         check_eq("xfer_data", memDataOut, e.data);
      end
   endtask

   // RAM model: synchronous write, read data one cycle after the address
   always @(posedge clk) begin
      if (ramWriteOut) begin
         ram[ramAddrOut[15:0]] <= ramDataOut;
      end
      ram_rd <= ram[ramAddrOut[15:0]];
   end

   // Monitor: RAM writes and rising completion pulses against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (ramWriteOut) begin
            wr_count <= wr_count + 1;
            check_eq("write_expected", 128'(wr_q.size() != 0), 128'(1));
            if (wr_q.size() != 0) begin
               check_eq("ram_write", 128'({ramAddrOut, ramDataOut}), 128'(wr_q.pop_front()));
            end
         end
         if (memDataValid && !mdv_prev) begin
            fill_pulses <= fill_pulses + 1;
            take_xfer(1'b1);
         end
         if (acceptWrite && !acc_prev) begin
            acc_pulses <= acc_pulses + 1;
            take_xfer(1'b0);
         end
      end
      mdv_prev <= memDataValid;
      acc_prev <= acceptWrite;
   end

   task automatic start_xfer(input bit fill, input logic [31:4] a, input logic [127:0] d, input bit hold);
      xfer_t x;
      miss  = 1'b1;
      rw    = fill;
      maddr = a;
      wb    = d;
      x.fill = fill;
      x.addr = a;
      x.data = d;
      xfer_q.push_back(x);
      if (!fill) begin
         for (int i = 0; i < 16; i++) begin
            wr_q.push_back({a, 4'(i), d[i*8 +: 8]});
         end
      end
      @(posedge clk);
      #1;
      if (!hold) miss = 1'b0;
   endtask

   task automatic wait_pulse(input bit fill, output int n);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (fill ? memDataValid : acceptWrite) return;
         if (chk_en) check_eq("fill_addr_step", 128'(ramAddrOut), 128'(chk_base + 32'((n > 15) ? 15 : n)));
         @(posedge clk);
         n++;
         #1;
         if (n == stall_at) ready = 1'b0;
         if (n == stall_at + stall_len) ready = 1'b1;
      end
      @(negedge clk);
      check_eq("pulse_seen", 128'(fill ? memDataValid : acceptWrite), 128'(1));
   endtask

   initial begin
      int           n;
      int           wc0;
      int           pc0;
      logic [127:0] fill_line;
      logic [127:0] rnd_line;
      logic [127:0] d;

      rst_n = 1'b0;
      ready = 1'b1;
      miss  = 1'b0;
      rw    = 1'b0;
      maddr = '0;
      wb    = '0;
      for (int i = 0; i < 16; i++) begin
         ram[16'h0100 + 16'(i)] = 8'hA0 + 8'(i);
         fill_line[i*8 +: 8]    = 8'hA0 + 8'(i);
      end

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", 128'(busy), 128'(0));
      check_eq("rst_valid", 128'(memDataValid), 128'(0));
      check_eq("rst_accept", 128'(acceptWrite), 128'(0));
      check_eq("rst_we", 128'(ramWriteOut), 128'(0));
      check_eq("rst_addr", 128'(ramAddrOut), 128'(0));
      check_eq("rst_wdata", 128'(ramDataOut), 128'(0));
      check_eq("rst_memdata", memDataOut, 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // plain fill
      wc0 = wr_count;
      chk_en = 1'b1;
      chk_base = 32'h0000_0100;
      start_xfer(1'b1, 28'h000_0010, fill_line, 1'b0);
      wait_pulse(1'b1, n);
      chk_en = 1'b0;
      check_eq("fill_latency", 128'(n), 128'(17));
      @(negedge clk);
      #1;
      check_eq("fill_pulse_width", 128'(memDataValid), 128'(0));
      check_eq("fill_pulse_count", 128'(fill_pulses), 128'(1));
      check_eq("fill_no_writes", 128'(wr_count - wc0), 128'(0));
      check_eq("memaddr_hold", 128'(memAddr), 128'(28'h000_0010));

      // plain write-back
      for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i);
      wc0 = wr_count;
      start_xfer(1'b0, 28'h000_07FF, d, 1'b0);
      wait_pulse(1'b0, n);
      check_eq("wb_latency", 128'(n), 128'(16));
      @(negedge clk);
      #1;
      check_eq("wb_pulse_width", 128'(acceptWrite), 128'(0));
      check_eq("wb_write_count", 128'(wr_count - wc0), 128'(16));
      check_eq("wb_accept_count", 128'(acc_pulses), 128'(1));
      check_eq("wb_no_fill_pulse", 128'(fill_pulses), 128'(1));

      // fill with a 3-cycle stall at cnt=7
      for (int i = 0; i < 16; i++) begin
         rnd_line[i*8 +: 8] = 8'($urandom_range(0, 255));
         ram[16'h0200 + 16'(i)] = rnd_line[i*8 +: 8];
      end
      wc0 = wr_count;
      stall_at = 7;
      stall_len = 3;
      start_xfer(1'b1, 28'h000_0020, rnd_line, 1'b0);
      wait_pulse(1'b1, n);
      stall_at = -1;
      stall_len = 0;
      check_eq("stall_latency", 128'(n), 128'(28));
      @(negedge clk);
      #1;
      check_eq("stall_no_writes", 128'(wr_count - wc0), 128'(0));
      check_eq("stall_pulse_count", 128'(fill_pulses), 128'(2));

      // stall while the write-back completion pulse is up
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_xfer(1'b0, 28'h000_0123, d, 1'b0);
      wait_pulse(1'b0, n);
      check_eq("done_wb_latency", 128'(n), 128'(16));
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("done_stall_hold", 128'(acceptWrite), 128'(1));
      end
      ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("done_stall_drop", 128'(acceptWrite), 128'(0));
      check_eq("done_stall_idle", 128'(busy), 128'(0));
      #1;
      check_eq("done_stall_count", 128'(acc_pulses), 128'(2));

      // asynchronous reset in the middle of a write-back
      @(posedge clk);
      #1;
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      miss  = 1'b1;
      rw    = 1'b0;
      maddr = 28'h000_0055;
      wb    = d;
      for (int i = 0; i < 9; i++) wr_q.push_back({28'h000_0055, 4'(i), d[i*8 +: 8]});
      @(posedge clk);
      #1;
      miss = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check_eq("rst_mid_addr", 128'(ramAddrOut), 128'(32'h0000_0559));
      pc0 = fill_pulses + acc_pulses;
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_we", 128'(ramWriteOut), 128'(0));
      check_eq("rst_async_busy", 128'(busy), 128'(0));
      check_eq("rst_async_addr", 128'(ramAddrOut), 128'(0));
      check_eq("rst_async_wdata", 128'(ramDataOut), 128'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check_eq("rst_after_busy", 128'(busy), 128'(0));
      check_eq("rst_no_pulse", 128'(fill_pulses + acc_pulses), 128'(pc0));
      check_eq("rst_writes_done", 128'(wr_q.size()), 128'(0));

      // back-to-back: miss held through a write-back, then a fill
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_xfer(1'b0, 28'h000_00AB, d, 1'b1);
      wait_pulse(1'b0, n);
      check_eq("b2b_wb_latency", 128'(n), 128'(16));
      rw    = 1'b1;
      maddr = 28'h000_0010;
      begin
         xfer_t x;
         x.fill = 1'b1;
         x.addr = 28'h000_0010;
         x.data = fill_line;
         xfer_q.push_back(x);
      end
      @(posedge clk);
      @(negedge clk);
      check_eq("b2b_idle_gap", 128'(busy), 128'(0));
      @(posedge clk);
      #1;
      miss = 1'b0;
      chk_en = 1'b1;
      chk_base = 32'h0000_0100;
      wait_pulse(1'b1, n);
      chk_en = 1'b0;
      check_eq("b2b_fill_latency", 128'(n), 128'(17));

      repeat (2) @(posedge clk);
      #1;
      check_eq("xfer_queue_drained", 128'(xfer_q.size()), 128'(0));
      check_eq("write_queue_drained", 128'(wr_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
